regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the core's decode/operand-fetch stage.
- Successor to the 2R/1W file: configurable XLEN, register count, read-port count and write-port count.
- Adds write-to-read bypass in the same cycle and a per-register busy scoreboard, so issue logic can detect RAW hazards on in-flight producers.
- Register 0 is hardwired zero.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 39 +++
 rtl/regfile_mp.sv | 78 +++++++
 tb/tb_regfile_mp.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared defaults, helpers and types for the multi-port
// integer register file.
package rf_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int AW_DEFAULT       = $clog2(NUM_REGS_DEFAULT);

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

  typedef logic [AW_DEFAULT-1:0]   rf_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on reserve, cleared on write,
// reserve wins over a same-cycle write.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEFAULT,
  parameter int NUM_WRITE = 1,
  parameter int AW        = rf_aw(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  input  logic [NUM_WRITE-1:0]  wr_en,
  input  logic [NUM_WRITE*AW-1:0] wr_addr,
  output logic [NUM_REGS-1:0]   next_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set;
  logic [NUM_REGS-1:0] clr;

  always_comb begin
    set = '0;
    clr = '0;
    if (rsv_en) set[rsv_addr] = 1'b1;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (wr_en[j]) clr[wr_addr[j*AW +: AW]] = 1'b1;
    end
    next_busy    = ((busy | set) & ~clr) | (set & clr);
    next_busy[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= next_busy;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-first
// bypass, busy scoreboard and stallable registered reads.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int NUM_REGS  = NUM_REGS_DEFAULT,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int AW        = rf_aw(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [NUM_READ*AW-1:0]    rs_addr,
  output logic [NUM_READ*XLEN-1:0]  rs_data,
  output logic [NUM_READ-1:0]       rs_busy,
  input  logic [NUM_WRITE-1:0]      wr_en,
  input  logic [NUM_WRITE*AW-1:0]   wr_addr,
  input  logic [NUM_WRITE*XLEN-1:0] wr_data,
  input  logic                      rsv_en,
  input  logic [AW-1:0]             rsv_addr
);

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [XLEN-1:0]     rd   [NUM_READ];
  logic [NUM_REGS-1:0] next_busy;

  rf_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .NUM_WRITE (NUM_WRITE),
    .AW        (AW)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .next_busy (next_busy)
  );

  // Later write ports are applied last, so the highest index wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd[i] = regs[rs_addr[i*AW +: AW]];
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == rs_addr[i*AW +: AW])
          rd[i] = wr_data[j*XLEN +: XLEN];
      end
      if (rs_addr[i*AW +: AW] == '0) rd[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_data <= '0;
      rs_busy <= '0;
    end else if (!stall) begin
      for (int i = 0; i < NUM_READ; i++) begin
        rs_data[i*XLEN +: XLEN] <= rd[i];
        rs_busy[i]              <= next_busy[rs_addr[i*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (2 read, 2 write ports).
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int AW   = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic [2*AW-1:0]   rs_addr;
  logic [2*XLEN-1:0] rs_data;
  logic [1:0]        rs_busy;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;

  int errors = 0;
  int checks = 0;

  regfile_mp #(
    .XLEN      (XLEN),
    .NUM_REGS  (NR),
    .NUM_READ  (2),
    .NUM_WRITE (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .rs_addr  (rs_addr),
    .rs_data  (rs_data),
    .rs_busy  (rs_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    rsv_en = 1'b0;
    stall  = 1'b0;
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] d0, d1;
    reset = 1'b1;
    idle();
    rs_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    tick();
    reset = 1'b0;
    checks++;
    if (rs_data !== '0 || rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_out: got data=%h busy=%b want 0/00",
               rs_data, rs_busy);
    end
    for (int a = 0; a < NR; a++) begin
      rs_addr = {5'(NR-1-a), 5'(a)};
      tick();
      d0 = rs_data[31:0];
      d1 = rs_data[63:32];
      checks++;
      if (d0 !== 32'h0 || d1 !== 32'h0 || rs_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_read a=%0d: got %h %h busy=%b want 0 0 00",
                 a, d0, d1, rs_busy);
      end
    end
  endtask

  task automatic test_write();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5};
    wr_data = {32'h0, 32'hDEADBEEF};
    rs_addr = {5'd0, 5'd1};
    tick();
    wr_en = 2'b00;
    rs_addr = {5'd0, 5'd5};
    tick();
    checks++;
    if (rs_data[31:0] !== 32'hDEADBEEF || rs_data[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL write_read: got %h %h want deadbeef 0",
               rs_data[31:0], rs_data[63:32]);
    end
    // writes to x0 must vanish, also from the bypass
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0};
    wr_data = {32'h0, 32'hCAFEF00D};
    rs_addr = {5'd0, 5'd0};
    tick();
    checks++;
    if (rs_data !== '0) begin
      errors++;
      $display("FAIL x0_bypass: got %h want 0", rs_data);
    end
    wr_en = 2'b00;
    tick();
    checks++;
    if (rs_data !== '0) begin
      errors++;
      $display("FAIL x0_array: got %h want 0", rs_data);
    end
  endtask

  task automatic test_bypass();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7};
    wr_data = {32'h0, 32'h12345678};
    rs_addr = {5'd5, 5'd7};
    tick();
    checks++;
    if (rs_data[31:0] !== 32'h12345678 ||
        rs_data[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass: got %h %h want 12345678 deadbeef",
               rs_data[31:0], rs_data[63:32]);
    end
    wr_en = 2'b00;
    rs_addr = {5'd7, 5'd0};
    tick();
    checks++;
    if (rs_data[63:32] !== 32'h12345678 || rs_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL bypass_array: got %h %h want 12345678 0",
               rs_data[63:32], rs_data[31:0]);
    end
  endtask

  task automatic test_conflict();
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3};
    wr_data = {32'h0000BBBB, 32'h0000AAAA};
    rs_addr = {5'd3, 5'd3};
    tick();
    checks++;
    if (rs_data[31:0] !== 32'hBBBB || rs_data[63:32] !== 32'hBBBB) begin
      errors++;
      $display("FAIL conflict_bypass: got %h %h want bbbb bbbb",
               rs_data[31:0], rs_data[63:32]);
    end
    wr_en = 2'b00;
    rs_addr = {5'd0, 5'd3};
    tick();
    checks++;
    if (rs_data[31:0] !== 32'hBBBB) begin
      errors++;
      $display("FAIL conflict_array: got %h want bbbb", rs_data[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    rs_addr = {5'd8, 5'd9};
    tick();
    checks++;
    if (rs_busy !== 2'b01) begin
      errors++;
      $display("FAIL rsv_set: got busy=%b want 01", rs_busy);
    end
    rsv_en = 1'b0;
    rs_addr = {5'd9, 5'd0};
    tick();
    checks++;
    if (rs_busy !== 2'b10) begin
      errors++;
      $display("FAIL rsv_hold: got busy=%b want 10", rs_busy);
    end
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0};
    wr_data = {32'h99, 32'h0};
    rs_addr = {5'd0, 5'd9};
    tick();
    checks++;
    if (rs_busy !== 2'b00 || rs_data[31:0] !== 32'h99) begin
      errors++;
      $display("FAIL wr_clear: got busy=%b data=%h want 00 99",
               rs_busy, rs_data[31:0]);
    end
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9};
    wr_data = {32'h0, 32'h9A};
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    checks++;
    if (rs_busy !== 2'b01) begin
      errors++;
      $display("FAIL rsv_and_wr: got busy=%b want 01", rs_busy);
    end
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rs_addr = {5'd9, 5'd0};
    tick();
    checks++;
    if (rs_busy !== 2'b10) begin
      errors++;
      $display("FAIL rsv_x0: got busy=%b want 10", rs_busy);
    end
    // write to a non-busy register keeps it clear
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd8};
    wr_data = {32'h0, 32'h88};
    rs_addr = {5'd0, 5'd8};
    tick();
    wr_en = 2'b00;
    checks++;
    if (rs_busy !== 2'b00 || rs_data[31:0] !== 32'h88) begin
      errors++;
      $display("FAIL wr_nonbusy: got busy=%b data=%h want 00 88",
               rs_busy, rs_data[31:0]);
    end
  endtask

  task automatic test_stall();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4};
    wr_data = {32'h0, 32'h11};
    rs_addr = {5'd0, 5'd0};
    tick();
    wr_en = 2'b00;
    rs_addr = {5'd0, 5'd4};
    tick();
    checks++;
    if (rs_data[31:0] !== 32'h11) begin
      errors++;
      $display("FAIL stall_pre: got %h want 11", rs_data[31:0]);
    end
    stall = 1'b1;
    wr_en = 2'b01; wr_data = {32'h0, 32'h22};
    rsv_en = 1'b1; rsv_addr = 5'd6;
    rs_addr = {5'd0, 5'd6};
    tick();
    wr_en = 2'b00; rsv_en = 1'b0;
    tick();
    checks++;
    if (rs_data[31:0] !== 32'h11 || rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL stall_hold: got %h busy=%b want 11 00",
               rs_data[31:0], rs_busy);
    end
    stall = 1'b0;
    rs_addr = {5'd6, 5'd4};
    tick();
    checks++;
    if (rs_data[31:0] !== 32'h22 || rs_busy !== 2'b10) begin
      errors++;
      $display("FAIL stall_release: got %h busy=%b want 22 10",
               rs_data[31:0], rs_busy);
    end
    // reset during stall, with a write and reserve pending
    stall = 1'b1; reset = 1'b1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd10};
    wr_data = {32'h0, 32'h55};
    rsv_en = 1'b1; rsv_addr = 5'd11;
    tick();
    checks++;
    if (rs_data !== '0 || rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_stall: got %h busy=%b want 0 00",
               rs_data, rs_busy);
    end
    reset = 1'b0;
    idle();
    rs_addr = {5'd10, 5'd4};
    tick();
    checks++;
    if (rs_data !== '0 || rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_clears: got %h busy=%b want 0 00",
               rs_data, rs_busy);
    end
    rs_addr = {5'd11, 5'd6};
    tick();
    checks++;
    if (rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy: got busy=%b want 00", rs_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
